// File: rtl/frame_double_buffer_pkg.sv
// Shared defaults, state encoding and helpers for the VGA frame double buffer.
package frame_double_buffer_pkg;

    localparam int unsigned FB_WIDTH      = 8;
    localparam int unsigned FB_HEIGHT     = 6;
    localparam int unsigned FB_PIXEL_SIZE = 3;

    typedef enum logic [1:0] {
        FbIdle  = 2'd0,
        FbClear = 2'd1,
        FbSwap  = 2'd2
    } fb_state_e;

    // Coordinate width for a dimension of n entries, never narrower than one bit.
    function automatic int unsigned coord_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_double_buffer_raster_counter.sv
// Raster-order x/y counter: x wraps at WIDTH-1 and carries into y.
// Shared between the buffer clear sequence and VGA timing.
module frame_double_buffer_raster_counter
    import frame_double_buffer_pkg::*;
#(
    parameter int unsigned WIDTH  = FB_WIDTH,
    parameter int unsigned HEIGHT = FB_HEIGHT,
    parameter int unsigned XW     = coord_width(WIDTH),
    parameter int unsigned YW     = coord_width(HEIGHT)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_end, y_end;

    assign x_end = (32'(x_q) == WIDTH - 1);
    assign y_end = (32'(y_q) == HEIGHT - 1);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (start) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = x_end && y_end;

endmodule

// File: rtl/frame_double_buffer.sv
// Double-buffered frame store: draw engine writes the back buffer, scan-out reads
// the front buffer, and the two swap only on a frame_start after a request.
module frame_double_buffer
    import frame_double_buffer_pkg::*;
#(
    parameter int unsigned            WIDTH       = FB_WIDTH,
    parameter int unsigned            HEIGHT      = FB_HEIGHT,
    parameter int unsigned            PIXEL_SIZE  = FB_PIXEL_SIZE,
    parameter logic [PIXEL_SIZE-1:0]  CLEAR_VALUE = '0,
    parameter int unsigned            XW          = coord_width(WIDTH),
    parameter int unsigned            YW          = coord_width(HEIGHT)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [XW-1:0]         wr_x,
    input  logic [YW-1:0]         wr_y,
    input  logic [PIXEL_SIZE-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  clear_req,
    input  logic                  swap_req,
    output logic                  swap_done,
    input  logic                  frame_start,
    input  logic [XW-1:0]         rd_x,
    input  logic [YW-1:0]         rd_y,
    output logic [PIXEL_SIZE-1:0] rd_data,
    output logic                  front_sel,
    output logic                  busy
);

    logic [PIXEL_SIZE-1:0] mem_q [2][HEIGHT][WIDTH];
    logic [PIXEL_SIZE-1:0] mem_d [2][HEIGHT][WIDTH];
    logic [PIXEL_SIZE-1:0] rd_data_q, rd_data_d;
    fb_state_e             state_q, state_d;
    logic                  front_sel_q, front_sel_d;
    logic                  swap_pend_q, swap_pend_d;
    logic                  swap_done_q, swap_done_d;

    logic                  back_sel;
    logic                  wr_accept;
    logic                  rd_in_range;
    logic                  cnt_start, cnt_en, cnt_last;
    logic [XW-1:0]         cnt_x;
    logic [YW-1:0]         cnt_y;

    frame_double_buffer_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_clear_cnt (
        .clk    (clk),
        .resetn (resetn),
        .start  (cnt_start),
        .en     (cnt_en),
        .x      (cnt_x),
        .y      (cnt_y),
        .last   (cnt_last)
    );

    assign back_sel    = ~front_sel_q;
    // Out-of-range writes are still accepted (wr_ready) but never touch storage.
    assign wr_accept   = wr_en && (state_q == FbIdle) &&
                         (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    assign rd_in_range = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_pend_d = swap_pend_q;
        swap_done_d = 1'b0;
        cnt_start   = 1'b0;
        cnt_en      = 1'b0;
        mem_d       = mem_q;

        unique case (state_q)
            FbIdle: begin
                if (clear_req) begin
                    state_d     = FbClear;
                    cnt_start   = 1'b1;
                    swap_pend_d = swap_pend_q | swap_req;
                end else if (swap_req || swap_pend_q) begin
                    if (frame_start) begin
                        front_sel_d = ~front_sel_q;
                        swap_pend_d = 1'b0;
                        swap_done_d = 1'b1;
                    end else begin
                        state_d = FbSwap;
                    end
                end
            end
            FbClear: begin
                cnt_en                          = 1'b1;
                mem_d[back_sel][cnt_y][cnt_x]   = CLEAR_VALUE;
                swap_pend_d                     = swap_pend_q | swap_req;
                if (cnt_last) begin
                    state_d = swap_pend_d ? FbSwap : FbIdle;
                end
            end
            FbSwap: begin
                if (frame_start) begin
                    front_sel_d = ~front_sel_q;
                    swap_pend_d = 1'b0;
                    swap_done_d = 1'b1;
                    state_d     = FbIdle;
                end
            end
            default: state_d = FbIdle;
        endcase

        // back_sel uses the pre-swap front, so a write in the swap cycle lands
        // in the buffer that is about to become visible.
        if (wr_accept) begin
            mem_d[back_sel][wr_y][wr_x] = wr_data;
        end

        rd_data_d = '0;
        if (rd_in_range) begin
            rd_data_d = mem_q[front_sel_q][rd_y][rd_x];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q       <= '{default: '0};
            rd_data_q   <= '0;
            state_q     <= FbIdle;
            front_sel_q <= 1'b0;
            swap_pend_q <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd_data_q   <= rd_data_d;
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_pend_q <= swap_pend_d;
            swap_done_q <= swap_done_d;
        end
    end

    assign wr_ready  = (state_q == FbIdle);
    assign busy      = (state_q != FbIdle);
    assign rd_data   = rd_data_q;
    assign front_sel = front_sel_q;
    assign swap_done = swap_done_q;

endmodule

// File: tb/tb_frame_double_buffer.sv
// Self-checking bench for frame_double_buffer: directed vector table, corner
// sequences, and random traffic against a behavioural frame-store model.
module tb_frame_double_buffer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam logic [2:0] CV = 3'b111;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_x = '0, wr_y = '0, wr_data = '0;
    logic       wr_ready;
    logic       clear_req = 1'b0, swap_req = 1'b0, frame_start = 1'b0;
    logic       swap_done;
    logic [2:0] rd_x = '0, rd_y = '0;
    logic [2:0] rd_data;
    logic       front_sel, busy;

    frame_double_buffer #(
        .CLEAR_VALUE (CV)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .clear_req   (clear_req),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .frame_start (frame_start),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_data     (rd_data),
        .front_sel   (front_sel),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: two pixel planes, a front index, and the pending work.
    logic [2:0] m_mem [2][H][W];
    logic       m_front, m_pend, m_wait, m_clearing, m_done;
    int         m_idx;
    logic [2:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) m_mem[b][y][x] = '0;
        m_front = 0; m_pend = 0; m_wait = 0; m_clearing = 0; m_done = 0; m_idx = 0;
        m_rd = '0;
    endtask

    task automatic model_step();
        logic f;
        f = m_front;
        m_rd = (int'(rd_x) < W && int'(rd_y) < H) ? m_mem[f][rd_y][rd_x] : 3'd0;
        m_done = 0;
        if (!m_clearing && !m_wait && wr_en && int'(wr_x) < W && int'(wr_y) < H)
            m_mem[!f][wr_y][wr_x] = wr_data;
        if (m_clearing) begin
            m_mem[!f][m_idx / W][m_idx % W] = CV;
            if (swap_req) m_pend = 1;
            m_idx++;
            if (m_idx == W * H) begin
                m_clearing = 0;
                m_wait     = m_pend;
            end
        end else if (m_wait) begin
            if (frame_start) begin
                m_front = !f; m_pend = 0; m_wait = 0; m_done = 1;
            end
        end else if (clear_req) begin
            m_clearing = 1; m_idx = 0;
            if (swap_req) m_pend = 1;
        end else if (swap_req || m_pend) begin
            if (frame_start) begin
                m_front = !f; m_pend = 0; m_done = 1;
            end else begin
                m_wait = 1;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("rd_data", 32'(rd_data), 32'(m_rd));
        check("front_sel", 32'(front_sel), 32'(m_front));
        check("swap_done", 32'(swap_done), 32'(m_done));
        check("busy", 32'(busy), 32'(m_clearing || m_wait));
        check("wr_ready", 32'(wr_ready), 32'(!(m_clearing || m_wait)));
    endtask

    task automatic idle_inputs();
        wr_en = 0; clear_req = 0; swap_req = 0; frame_start = 0;
    endtask

    task automatic scan_const(input logic [2:0] v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                rd_x = 3'(x); rd_y = 3'(y);
                step();
                check("scan_pixel", 32'(rd_data), 32'(v));
            end
    endtask

    task automatic async_reset();
        #2 resetn = 0;
        idle_inputs();
        #1;
        check("rst_front", 32'(front_sel), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_swap_done", 32'(swap_done), 0);
        @(posedge clk);
        #1 resetn = 1;
        model_reset();
        check("rst_wr_ready", 32'(wr_ready), 1);
    endtask

    typedef struct {
        logic       wr_en;
        logic [2:0] wr_x, wr_y, wr_data;
        logic       clear_req, swap_req, frame_start;
        logic [2:0] rd_x, rd_y;
        logic [2:0] e_rd;
        logic       e_front, e_done, e_busy;
    } vec_t;

    vec_t vecs[15];
    int   busy_cycles;

    initial begin
        // wr_en x y d clr swp fs rdx rdy | rd front done busy
        vecs[0]  = '{1'b1, 3'd2, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1};
        for (int i = 3; i < 7; i++)
            vecs[i] = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 3'd5, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 3'd3, 3'd4, 3'd6, 1'b0, 1'b0, 1'b0, 3'd3, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd4, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 1'b0, 3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 3'd5, 3'd7, 3'd3, 1'b0, 1'b0, 1'b0, 3'd7, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        check("init_front", 32'(front_sel), 0);
        check("init_wr_ready", 32'(wr_ready), 1);

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr_en; wr_x = vecs[i].wr_x; wr_y = vecs[i].wr_y;
            wr_data = vecs[i].wr_data; clear_req = vecs[i].clear_req;
            swap_req = vecs[i].swap_req; frame_start = vecs[i].frame_start;
            rd_x = vecs[i].rd_x; rd_y = vecs[i].rd_y;
            step();
            check($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vecs[i].e_rd));
            check($sformatf("vec%0d_front", i), 32'(front_sel), 32'(vecs[i].e_front));
            check($sformatf("vec%0d_done", i), 32'(swap_done), 32'(vecs[i].e_done));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end
        idle_inputs();

        // Clear alone: busy for exactly W*H cycles, writes refused throughout.
        clear_req = 1;
        step();
        clear_req = 0;
        wr_en = 1; wr_x = 3'd1; wr_y = 3'd1; wr_data = 3'd2;
        busy_cycles = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            busy_cycles++;
            check("clear_wr_ready", 32'(wr_ready), 0);
            step();
        end
        wr_en = 0;
        check("clear_len", busy_cycles, W * H);
        swap_req = 1; frame_start = 1;
        step();
        idle_inputs();
        check("clear_swap_front", 32'(front_sel), 1);
        scan_const(CV);

        // Swap requested mid-clear waits for the clear and then a frame_start.
        clear_req = 1;
        step();
        clear_req = 0;
        for (int i = 0; i < 60; i++) begin
            swap_req    = (i == 5);
            frame_start = (i == 20);
            step();
        end
        idle_inputs();
        check("pend_front", 32'(front_sel), 1);
        check("pend_busy", 32'(busy), 1);
        frame_start = 1;
        step();
        frame_start = 0;
        check("pend_swap_front", 32'(front_sel), 0);
        check("pend_swap_done", 32'(swap_done), 1);
        step();
        check("pend_done_pulse", 32'(swap_done), 0);
        frame_start = 1;
        step();
        frame_start = 0;
        check("stray_fs_front", 32'(front_sel), 0);
        scan_const(CV);

        // Reset in the middle of a clear: everything back to zero.
        clear_req = 1;
        step();
        clear_req = 0;
        repeat (10) step();
        async_reset();
        scan_const(3'd0);
        swap_req = 1; frame_start = 1;
        step();
        idle_inputs();
        check("rst_swap_front", 32'(front_sel), 1);
        scan_const(3'd0);

        // Reset while a swap is pending: no swap survives.
        swap_req = 1;
        step();
        swap_req = 0;
        repeat (3) step();
        async_reset();
        frame_start = 1;
        step();
        frame_start = 0;
        check("rst_pend_front", 32'(front_sel), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wr_en       = 1'($urandom_range(0, 1));
            wr_x        = 3'($urandom);
            wr_y        = 3'($urandom);
            wr_data     = 3'($urandom);
            clear_req   = ($urandom_range(0, 63) == 0);
            swap_req    = ($urandom_range(0, 15) == 0);
            frame_start = ($urandom_range(0, 11) == 0);
            rd_x        = 3'($urandom);
            rd_y        = 3'($urandom);
            step();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
